// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// Miss handler between a direct-mapped cache and a pipelined main memory.
// On a miss it fetches the whole block with one word read per cycle. It
// streams each returned word into the data array and writes the tag when
// the final word arrives. The pipeline stall is held for the whole fill.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   miss_detected     lookup missed this cycle (level)
//   miss_address      byte address of the missing access
//   memory_data_valid memory read data valid this cycle
//   fsm_busy          stall request to the pipeline/cache
//   memory_enable     read request to memory this cycle
//   memory_address    address of the current read request
//   write_data_array  write the returned word into the data array
//   fill_word_idx     word offset within the block for write_data_array
//   write_tag_array   write tag and valid bit for the filled block
//
// Handshake: the memory side has no back-pressure. Each cycle with
// memory_enable=1 is exactly one accepted request. Each cycle with
// memory_data_valid=1 is exactly one returned word, in request order.
// The returned word is consumed that same cycle.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    output logic                               fsm_busy,
    output logic                               memory_enable,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic                               write_tag_array
);

    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    // Byte-offset bits within a block (2 bytes per word).
    localparam int OFF_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic              mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [ADDR_W-1:0] block_base;
    logic              in_fill;

    assign block_base = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign in_fill    = (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Valids seen while idle are stray and are dropped.
                    if (miss_detected) begin
                        state      <= FILL;
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= block_base;
                    end
                end
                FILL: begin
                    // Issue side: one request per cycle until the block is covered.
                    // The address stays inside the block, so no carry out of it.
                    if (mem_en_q) begin
                        if (issue_cnt == LAST_IDX) begin
                            mem_en_q <= 1'b0;
                        end else begin
                            issue_cnt  <= issue_cnt + 1'b1;
                            mem_addr_q <= mem_addr_q + ADDR_W'(2);
                        end
                    end
                    // Receive side: count valids. Completion depends only on the
                    // word count, never on memory latency.
                    if (memory_data_valid) begin
                        if (recv_cnt == LAST_IDX) begin
                            state     <= IDLE;
                            recv_cnt  <= '0;
                            issue_cnt <= '0;
                            mem_en_q  <= 1'b0;
                        end else begin
                            recv_cnt <= recv_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign memory_enable    = mem_en_q;
    assign memory_address   = mem_addr_q;
    // Array writes track the returned data in the same cycle.
    assign write_data_array = in_fill & memory_data_valid;
    assign fill_word_idx    = write_data_array ? recv_cnt : '0;
    assign write_tag_array  = write_data_array & (recv_cnt == LAST_IDX);
    // The stall also covers the detection cycle, so it is combinational.
    assign fsm_busy         = in_fill | miss_detected;

endmodule
